// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: arbitrates the regfile write port between WB and a one-entry LU result slot.
// Optional perf counters (FORCE/HOLD cycle counts) are enabled by defining WPORT_PERF_CNT_EN.
module rf_wport_arbiter #(
   parameter int MAX_WAIT = 4
) (
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic        wb_valid_i,
   input  logic        wb_we_i,
   input  logic [4:0]  wb_waddr_i,
   input  logic [31:0] wb_wdata_i,
   input  logic [31:0] wb_pc_i,
   output logic        wb_ready_o,
   input  logic        lu_valid_i,
   input  logic [4:0]  lu_waddr_i,
   input  logic [31:0] lu_wdata_i,
   input  logic [31:0] lu_pc_i,
   output logic        lu_ready_o,
   output logic        lu_pending_o,
   output logic [4:0]  lu_pend_addr_o,
`ifdef WPORT_PERF_CNT_EN
   output logic [31:0] perf_wb_stall_o,
   output logic [31:0] perf_lu_wait_o,
`endif
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   output logic [31:0] debug_wb_pc_o,
   output logic [3:0]  debug_wb_rf_we_o,
   output logic [4:0]  debug_wb_rf_wnum_o,
   output logic [31:0] debug_wb_rf_wdata_o
);
   localparam int CW = $clog2(MAX_WAIT + 1);
   typedef enum logic [1:0] {IDLE, HOLD, FORCE} state_t;
   state_t      state_q, state_d;
   logic [4:0]  slot_addr_q, slot_addr_d;
   logic [31:0] slot_data_q, slot_data_d;
   logic [31:0] slot_pc_q, slot_pc_d;
   logic [CW-1:0] wait_q, wait_d;
   logic        wb_wr, grant_wb, grant_lu;
   assign wb_wr = wb_valid_i & wb_we_i;
   always_comb begin
      state_d     = state_q;
      slot_addr_d = slot_addr_q;
      slot_data_d = slot_data_q;
      slot_pc_d   = slot_pc_q;
      wait_d      = wait_q;
      wb_ready_o  = 1'b0;
      lu_ready_o  = 1'b0;
      grant_wb    = 1'b0;
      grant_lu    = 1'b0;
      case (state_q)
         IDLE: begin
            wb_ready_o = 1'b1;
            lu_ready_o = 1'b1;
            grant_wb   = wb_wr;
            // r0 results are accepted but never occupy the slot
            if (lu_valid_i && lu_waddr_i != 5'd0) begin
               slot_addr_d = lu_waddr_i;
               slot_data_d = lu_wdata_i;
               slot_pc_d   = lu_pc_i;
               wait_d      = '0;
               state_d     = HOLD;
            end
         end
         HOLD: begin
            wb_ready_o = 1'b1;
            grant_wb   = wb_wr;
            grant_lu   = !wb_wr;
            if (!wb_wr || wb_waddr_i == slot_addr_q) begin
               wait_d  = '0;
               state_d = IDLE;
            end else if (wait_q == CW'(MAX_WAIT - 1)) begin
               state_d = FORCE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         FORCE: begin
            grant_lu = 1'b1;
            wait_d   = '0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (!resetn_i) begin
         wb_ready_o = 1'b0;
         lu_ready_o = 1'b0;
         grant_wb   = 1'b0;
         grant_lu   = 1'b0;
      end
   end
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state_q     <= IDLE;
         slot_addr_q <= '0;
         slot_data_q <= '0;
         slot_pc_q   <= '0;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         slot_addr_q <= slot_addr_d;
         slot_data_q <= slot_data_d;
         slot_pc_q   <= slot_pc_d;
         wait_q      <= wait_d;
      end
   end
   assign lu_pending_o        = resetn_i && state_q != IDLE;
   assign lu_pend_addr_o      = lu_pending_o ? slot_addr_q : 5'd0;
   assign rf_we_o             = grant_wb | grant_lu;
   assign rf_waddr_o          = grant_wb ? wb_waddr_i : grant_lu ? slot_addr_q : 5'd0;
   assign rf_wdata_o          = grant_wb ? wb_wdata_i : grant_lu ? slot_data_q : 32'd0;
   assign debug_wb_pc_o       = grant_lu ? slot_pc_q : wb_pc_i;
   assign debug_wb_rf_we_o    = {4{rf_we_o}};
   assign debug_wb_rf_wnum_o  = rf_waddr_o;
   assign debug_wb_rf_wdata_o = rf_wdata_o;
`ifdef WPORT_PERF_CNT_EN
   logic [31:0] stall_q, lwait_q;
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         stall_q <= '0;
         lwait_q <= '0;
      end else begin
         stall_q <= stall_q + 32'(state_q == FORCE);
         lwait_q <= lwait_q + 32'(state_q == HOLD);
      end
   end
   assign perf_wb_stall_o = stall_q;
   assign perf_lu_wait_o  = lwait_q;
`endif
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter: scoreboard bench; a slot-level reference model queues expected port
// behaviour per cycle and a negedge monitor compares it against the arbiter outputs.
module tb_rf_wport_arbiter;
   localparam int MW = 4;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic resetn, wb_valid, wb_we, lu_valid;
   logic [4:0] wb_waddr, lu_waddr;
   logic [31:0] wb_wdata, wb_pc, lu_wdata, lu_pc;
   logic wb_ready, lu_ready, lu_pending, rf_we;
   logic [4:0] lu_pend_addr, rf_waddr, dbg_wnum;
   logic [31:0] rf_wdata, dbg_pc, dbg_wdata;
   logic [3:0] dbg_we;
   rf_wport_arbiter #(.MAX_WAIT(MW)) dut (
      .clk_i(clk), .resetn_i(resetn),
      .wb_valid_i(wb_valid), .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
      .wb_pc_i(wb_pc), .wb_ready_o(wb_ready),
      .lu_valid_i(lu_valid), .lu_waddr_i(lu_waddr), .lu_wdata_i(lu_wdata), .lu_pc_i(lu_pc),
      .lu_ready_o(lu_ready), .lu_pending_o(lu_pending), .lu_pend_addr_o(lu_pend_addr),
      .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
      .debug_wb_pc_o(dbg_pc), .debug_wb_rf_we_o(dbg_we), .debug_wb_rf_wnum_o(dbg_wnum),
      .debug_wb_rf_wdata_o(dbg_wdata)
   );
   typedef struct {
      logic wbr, lur, pend, we;
      logic [4:0] paddr, wa;
      logic [31:0] wd, pc;
   } exp_t;
   exp_t sb[$];
   int n_vec = 0, n_bad = 0;
   // reference: one optional held result plus how many times WB has beaten it
   logic m_full = 1'b0;
   logic [4:0] m_addr = '0;
   logic [31:0] m_data = '0, m_pc = '0;
   int m_wins = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
      end
   endtask
   task automatic cyc(input logic rn, input logic wv, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [31:0] wp, input logic lv,
                      input logic [4:0] la, input logic [31:0] ld, input logic [31:0] lp);
      exp_t e;
      logic wr;
      @(posedge clk);
      #1;
      resetn = rn; wb_valid = wv; wb_we = we; wb_waddr = wa; wb_wdata = wd; wb_pc = wp;
      lu_valid = lv; lu_waddr = la; lu_wdata = ld; lu_pc = lp;
      wr = wv & we;
      e = '{wbr: 1'b0, lur: 1'b0, pend: 1'b0, we: 1'b0, paddr: 5'd0, wa: 5'd0, wd: 32'd0, pc: wp};
      if (!rn) begin
         m_full = 1'b0;
         m_wins = 0;
      end else begin
         e.pend  = m_full;
         e.paddr = m_full ? m_addr : 5'd0;
         if (!m_full) begin
            e.wbr = 1'b1; e.lur = 1'b1;
            if (wr) begin e.we = 1'b1; e.wa = wa; e.wd = wd; end
            if (lv && la != 5'd0) begin
               m_full = 1'b1; m_addr = la; m_data = ld; m_pc = lp; m_wins = 0;
            end
         end else if (m_wins == MW || !wr) begin
            e.wbr = (m_wins != MW);
            e.we = 1'b1; e.wa = m_addr; e.wd = m_data; e.pc = m_pc;
            m_full = 1'b0;
         end else begin
            e.wbr = 1'b1;
            e.we = 1'b1; e.wa = wa; e.wd = wd;
            if (wa == m_addr) m_full = 1'b0;
            else m_wins++;
         end
      end
      sb.push_back(e);
   endtask
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("wb_ready", 32'(wb_ready), 32'(e.wbr));
         chk("lu_ready", 32'(lu_ready), 32'(e.lur));
         chk("lu_pending", 32'(lu_pending), 32'(e.pend));
         chk("lu_pend_addr", 32'(lu_pend_addr), 32'(e.paddr));
         chk("rf_we", 32'(rf_we), 32'(e.we));
         chk("rf_waddr", 32'(rf_waddr), 32'(e.wa));
         chk("rf_wdata", rf_wdata, e.wd);
         chk("debug_wb_pc", dbg_pc, e.pc);
         chk("debug_wb_rf_we", 32'(dbg_we), 32'({4{e.we}}));
         chk("debug_wb_rf_wnum", 32'(dbg_wnum), 32'(e.wa));
         chk("debug_wb_rf_wdata", dbg_wdata, e.wd);
      end
   end
   task automatic idle(input logic lv, input logic [4:0] la, input logic [31:0] ld);
      cyc(1, 0, 0, 0, 0, 32'h9000, lv, la, ld, 32'h8000 + ld);
   endtask
   task automatic wbw(input logic [4:0] wa, input logic [31:0] wd);
      cyc(1, 1, 1, wa, wd, 32'h4000 + 32'(wa), 0, 0, 0, 0);
   endtask
   initial begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 5'd3, 32'h33, 32'h10, 1, 5'd4, 32'h44, 32'h20);
      // result lands next cycle, WB idle
      idle(1, 5'd5, 32'h1234);
      idle(0, 0, 0);
      idle(0, 0, 0);
      // WB wins MAX_WAIT times, then one forced LU cycle stalls WB
      idle(1, 5'd7, 32'h77);
      wbw(5'd3, 32'h3); wbw(5'd4, 32'h4); wbw(5'd6, 32'h6); wbw(5'd8, 32'h8);
      wbw(5'd10, 32'hA); wbw(5'd10, 32'hA);
      // younger WB write to the same register discards the slot
      idle(1, 5'd9, 32'h99);
      wbw(5'd9, 32'hAA);
      idle(0, 0, 0);
      // r0 result dropped
      cyc(1, 1, 1, 5'd2, 32'h22, 32'h4002, 1, 5'd0, 32'h55, 32'h8055);
      idle(0, 0, 0);
      // back-pressure while the slot is full
      idle(1, 5'd11, 32'hB1);
      cyc(1, 1, 1, 5'd12, 32'hC, 32'h400C, 1, 5'd13, 32'hD1, 32'h80D1);
      idle(1, 5'd13, 32'hD1);
      idle(1, 5'd13, 32'hD1);
      idle(0, 0, 0);
      idle(0, 0, 0);
      // reset while forcing
      idle(1, 5'd14, 32'hE1);
      wbw(5'd1, 32'h1); wbw(5'd2, 32'h2); wbw(5'd3, 32'h3); wbw(5'd4, 32'h4);
      cyc(0, 1, 1, 5'd6, 32'h6, 32'h4006, 0, 0, 0, 0);
      wbw(5'd6, 32'h6);
      idle(0, 0, 0);
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
             5'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 1) != 0,
             5'($urandom_range(0, 15)), $urandom, $urandom);
      idle(0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
